// File: rtl/demux_1to4_64bit_stream.sv
// 1:4 valid/ready stream demux with a 2-entry FIFO per output.
// Optional per-port beat counters: define DEMUX_BEAT_CNT_EN.
module demux_1to4_64bit_stream #(
  parameter int WIDTH     = 64,
  parameter int SEL_WIDTH = 2,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_WIDTH-1:0] in_sel,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [WIDTH-1:0]     out_data0,
  output logic [WIDTH-1:0]     out_data1,
  output logic [WIDTH-1:0]     out_data2,
  output logic [WIDTH-1:0]     out_data3
`ifdef DEMUX_BEAT_CNT_EN
  ,
  output logic [15:0]          count0,
  output logic [15:0]          count1,
  output logic [15:0]          count2,
  output logic [15:0]          count3
`endif
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [1:0]       occ  [4];
  logic [WIDTH-1:0] head [4];
  logic [3:0]       push;
  logic [3:0]       pop;

  // Readiness looks only at registered occupancy, never out_ready.
  assign in_ready = (occ[in_sel] != FULL);
  assign pop      = out_valid & out_ready;

  // One-hot push strobe toward the addressed FIFO.
  always_comb begin
    push = '0;
    if (in_valid && in_ready) begin
      push[in_sel] = 1'b1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_port
    logic [WIDTH-1:0] mem [2];
    logic             wp;
    logic             rp;
    logic [1:0]       occ_q;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
      if (rst) begin
        mem[0] <= '0;
        mem[1] <= '0;
        wp     <= 1'b0;
        rp     <= 1'b0;
        occ_q  <= 2'd0;
      end else begin
        if (push[i]) begin
          mem[wp] <= in_data;
          wp      <= ~wp;
        end
        if (pop[i]) begin
          rp <= ~rp;
        end
        unique case (1'b1)
          push[i] && !pop[i]: occ_q <= occ_q + 2'd1;
          pop[i] && !push[i]: occ_q <= occ_q - 2'd1;
          default: ;
        endcase
      end
    end

    assign occ[i]       = occ_q;
    assign head[i]      = mem[rp];
    assign out_valid[i] = (occ_q != 2'd0);

`ifdef DEMUX_BEAT_CNT_EN
    logic [15:0] cnt_q;

    // Free-running count of beats accepted into this port.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= 16'd0;
      end else if (push[i]) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
`endif
  end

  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  assign out_data3 = head[3];

`ifdef DEMUX_BEAT_CNT_EN
  assign count0 = g_port[0].cnt_q;
  assign count1 = g_port[1].cnt_q;
  assign count2 = g_port[2].cnt_q;
  assign count3 = g_port[3].cnt_q;
`endif

endmodule

// File: tb/tb_demux_1to4_64bit_stream.sv
// Directed bench for demux_1to4_64bit_stream.
// Counter scenario runs when DEMUX_BEAT_CNT_EN is defined.
module tb_demux_1to4_64bit_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [63:0] out_data0;
  logic [63:0] out_data1;
  logic [63:0] out_data2;
  logic [63:0] out_data3;
`ifdef DEMUX_BEAT_CNT_EN
  logic [15:0] count0;
  logic [15:0] count1;
  logic [15:0] count2;
  logic [15:0] count3;
`endif

  int chk = 0;
  int err = 0;

  always #5 clk = ~clk;

  demux_1to4_64bit_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
`ifdef DEMUX_BEAT_CNT_EN
    ,
    .count0    (count0),
    .count1    (count1),
    .count2    (count2),
    .count3    (count3)
`endif
  );

  function automatic logic [63:0] port_data(input int k);
    case (k)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_sel = 2'd1;
    in_data = 64'h55;
    out_ready = 4'h0;
    tick();
    tick();
    #1;
    chk++;
    if (out_valid !== 4'b0000) begin
      err++;
      $display("FAIL reset_valid: got %b want 0000", out_valid);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      err++;
      $display("FAIL reset_after: valid %b rdy %b want 0000/1",
               out_valid, in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      chk++;
      if (port_data(k) !== 64'h0) begin
        err++;
        $display("FAIL reset_data%0d: got %h want 0", k, port_data(k));
      end
    end
    tick();
    chk++;
    if (out_valid !== 4'b0000) begin
      err++;
      $display("FAIL reset_nobeat: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_routing();
    out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_sel = 2'(k);
      in_data = 64'hA0 + 64'(k);
      #1;
      chk++;
      if (in_ready !== 1'b1) begin
        err++;
        $display("FAIL route_rdy%0d: got %b want 1", k, in_ready);
      end
      tick();
      chk++;
      if (out_valid !== 4'(1 << k) ||
          port_data(k) !== 64'hA0 + 64'(k)) begin
        err++;
        $display("FAIL route%0d: valid %b data %h want %b/%h",
                 k, out_valid, port_data(k), 4'(1 << k),
                 64'hA0 + 64'(k));
      end
    end
    in_valid = 1'b0;
    tick();
    chk++;
    if (out_valid !== 4'b0000) begin
      err++;
      $display("FAIL route_once: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1011;
    in_valid = 1'b1;
    in_sel = 2'd2;
    in_data = 64'hB0;
    tick();
    in_data = 64'hB1;
    tick();
    in_data = 64'hB2;
    #1;
    chk++;
    if (in_ready !== 1'b0 || out_valid[2] !== 1'b1 ||
        out_data2 !== 64'hB0) begin
      err++;
      $display("FAIL bp_full: rdy %b v2 %b d2 %h want 0/1/b0",
               in_ready, out_valid[2], out_data2);
    end
    tick();
    chk++;
    if (in_ready !== 1'b0 || out_data2 !== 64'hB0) begin
      err++;
      $display("FAIL bp_hold: rdy %b d2 %h want 0/b0",
               in_ready, out_data2);
    end
    in_sel = 2'd0;
    in_data = 64'hC0;
    #1;
    chk++;
    if (in_ready !== 1'b1) begin
      err++;
      $display("FAIL bp_other_rdy: got %b want 1", in_ready);
    end
    tick();
    chk++;
    if (out_valid !== 4'b0101 || out_data0 !== 64'hC0) begin
      err++;
      $display("FAIL bp_other_flow: valid %b d0 %h want 0101/c0",
               out_valid, out_data0);
    end
    in_sel = 2'd2;
    in_data = 64'hB2;
    out_ready = 4'hF;
    tick();
    chk++;
    if (out_data2 !== 64'hB1 || in_ready !== 1'b1 ||
        out_valid !== 4'b0100) begin
      err++;
      $display("FAIL bp_drain1: d2 %h rdy %b v %b want b1/1/0100",
               out_data2, in_ready, out_valid);
    end
    tick();
    chk++;
    if (out_data2 !== 64'hB2 || out_valid !== 4'b0100) begin
      err++;
      $display("FAIL bp_third: d2 %h v %b want b2/0100",
               out_data2, out_valid);
    end
    in_valid = 1'b0;
    tick();
    chk++;
    if (out_valid !== 4'b0000) begin
      err++;
      $display("FAIL bp_empty: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_full_pop();
    out_ready = 4'h0;
    in_valid = 1'b1;
    in_sel = 2'd1;
    in_data = 64'hD0;
    tick();
    in_data = 64'hD1;
    tick();
    in_data = 64'hD2;
    out_ready = 4'b0010;
    #1;
    chk++;
    if (in_ready !== 1'b0) begin
      err++;
      $display("FAIL fullpop_rdy: got %b want 0", in_ready);
    end
    tick();
    chk++;
    if (in_ready !== 1'b1 || out_data1 !== 64'hD1) begin
      err++;
      $display("FAIL fullpop_next: rdy %b d1 %h want 1/d1",
               in_ready, out_data1);
    end
    in_valid = 1'b0;
    out_ready = 4'hF;
    tick();
    chk++;
    if (out_valid !== 4'b0000) begin
      err++;
      $display("FAIL fullpop_empty: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 4'hF;
    in_sel = 2'd3;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data = 64'h1000 + 64'(i);
      #1;
      chk++;
      if (in_ready !== 1'b1) begin
        err++;
        $display("FAIL stream_rdy%0d: got %b want 1", i, in_ready);
      end
      tick();
      chk++;
      if (out_valid !== 4'b1000 ||
          out_data3 !== 64'h1000 + 64'(i)) begin
        err++;
        $display("FAIL stream%0d: v %b d3 %h want 1000/%h",
                 i, out_valid, out_data3, 64'h1000 + 64'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    chk++;
    if (out_valid !== 4'b0000) begin
      err++;
      $display("FAIL stream_end: got %b want 0000", out_valid);
    end
  endtask

`ifdef DEMUX_BEAT_CNT_EN
  task automatic test_counter();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    out_ready = 4'hF;
    in_sel = 2'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 65541; i++) begin
      in_data = 64'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk++;
    if (count0 !== 16'd5 || count1 !== 16'd0 ||
        count2 !== 16'd0 || count3 !== 16'd0) begin
      err++;
      $display("FAIL cnt_wrap: %0d %0d %0d %0d want 5 0 0 0",
               count0, count1, count2, count3);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk++;
    if (count0 !== 16'd0 || count1 !== 16'd0 ||
        count2 !== 16'd0 || count3 !== 16'd0) begin
      err++;
      $display("FAIL cnt_rst: %0d %0d %0d %0d want 0 0 0 0",
               count0, count1, count2, count3);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_sel = '0;
    out_ready = '0;
    test_reset();
    test_routing();
    test_backpressure();
    test_full_pop();
    test_back_to_back();
`ifdef DEMUX_BEAT_CNT_EN
    test_counter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
